// File: rtl/sdram_arbiter_if.sv
// Engine-side request/grant buses and SDRAM pin group shared by the arbiter.
// The arbiter connects through the slave modport; engines and pins sit on the master side.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DATA_W = 16
);
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;

    logic              aref_req;
    logic              aref_end;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              aref_en;

    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_sdram_data;
    logic              wr_en;

    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;

    logic              sdram_cke;
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_dq_out;
    logic              sdram_dq_oe;

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );

    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Grants the SDRAM command/address/data bus to one of init, refresh, write or read
// engines (refresh > write > read) and muxes the owner's signals onto the pins.
module sdram_arbiter #(
    parameter int         ADDR_W  = 13,
    parameter int         BA_W    = 2,
    parameter int         DATA_W  = 16,
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic           sdram_clk,
    input  logic           sdram_rst_n,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        pin_cmd_s;
    logic [BA_W-1:0]   pin_ba_s;
    logic [ADDR_W-1:0] pin_addr_s;
    logic [DATA_W-1:0] dq_out_s;
    logic              dq_oe_s;
    logic              aref_en_s;
    logic              wr_en_s;
    logic              rd_en_s;

    // State register
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: loss of init_end forces re-init from any state; owners run to their end pulse
    always_comb begin
        state_d = state_q;
        if (!bus.init_end && (state_q != ST_INIT)) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (bus.init_end) state_d = ST_IDLE;
                    else              state_d = ST_INIT;
                end
                ST_IDLE: begin
                    if (bus.aref_req)     state_d = ST_AREF;
                    else if (bus.wr_req)  state_d = ST_WRITE;
                    else if (bus.rd_req)  state_d = ST_READ;
                    else                  state_d = ST_IDLE;
                end
                ST_AREF: begin
                    if (bus.aref_end) state_d = ST_IDLE;
                    else              state_d = ST_AREF;
                end
                ST_WRITE: begin
                    if (bus.wr_end) state_d = ST_IDLE;
                    else            state_d = ST_WRITE;
                end
                ST_READ: begin
                    if (bus.rd_end) state_d = ST_IDLE;
                    else            state_d = ST_READ;
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // Output decode: while reset is held the pins park at NOP regardless of the init bus
    always_comb begin
        pin_cmd_s  = CMD_NOP;
        pin_ba_s   = {BA_W{1'b1}};
        pin_addr_s = {ADDR_W{1'b1}};
        dq_out_s   = {DATA_W{1'b0}};
        dq_oe_s    = 1'b0;
        aref_en_s  = 1'b0;
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        if (!sdram_rst_n) begin
            pin_cmd_s = CMD_NOP;
        end else begin
            case (state_q)
                ST_INIT: begin
                    pin_cmd_s  = bus.init_cmd;
                    pin_ba_s   = bus.init_ba;
                    pin_addr_s = bus.init_addr;
                end
                ST_IDLE: begin
                    pin_cmd_s = CMD_NOP;
                end
                ST_AREF: begin
                    aref_en_s  = 1'b1;
                    pin_cmd_s  = bus.aref_cmd;
                    pin_ba_s   = bus.aref_ba;
                    pin_addr_s = bus.aref_addr;
                end
                ST_WRITE: begin
                    wr_en_s    = 1'b1;
                    pin_cmd_s  = bus.wr_cmd;
                    pin_ba_s   = bus.wr_ba;
                    pin_addr_s = bus.wr_addr;
                    dq_out_s   = bus.wr_sdram_data;
                    dq_oe_s    = bus.wr_sdram_en;
                end
                ST_READ: begin
                    rd_en_s    = 1'b1;
                    pin_cmd_s  = bus.rd_cmd;
                    pin_ba_s   = bus.rd_ba;
                    pin_addr_s = bus.rd_addr;
                end
                default: pin_cmd_s = CMD_NOP;
            endcase
        end
    end

    assign bus.aref_en      = aref_en_s;
    assign bus.wr_en        = wr_en_s;
    assign bus.rd_en        = rd_en_s;
    assign bus.sdram_cke    = 1'b1;
    assign bus.sdram_cs_n   = pin_cmd_s[3];
    assign bus.sdram_ras_n  = pin_cmd_s[2];
    assign bus.sdram_cas_n  = pin_cmd_s[1];
    assign bus.sdram_we_n   = pin_cmd_s[0];
    assign bus.sdram_ba     = pin_ba_s;
    assign bus.sdram_addr   = pin_addr_s;
    assign bus.sdram_dq_out = dq_out_s;
    assign bus.sdram_dq_oe  = dq_oe_s;
endmodule
